ip_sequencer: RTL and testbench
===============================

IP_SEQUENCER -- requirements
Module: ip_sequencer

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: width of the instruction word, address offset and counters.
REQ-002 SHALL have parameter STEP, default 1: signed offset applied for sequential advance.
REQ-003 SHALL have parameter TIMEOUT, default 8: number of consecutive FETCH cycles without mem_ack before a fault is raised.
REQ-004 update_clk  in  1  clock; all state changes on its rising edge.
REQ-005 reset_clk  in  1  reset; asynchronous, active-high.
REQ-006 mem_req  out  1  instruction fetch request; high exactly while state is FETCH.
REQ-007 mem_ack  in  1  fetch data valid this cycle; ignored outside FETCH.
REQ-008 mem_rdata  in  WORD_SIZE  fetched instruction word.
REQ-009 instr  out  WORD_SIZE  held instruction word.
REQ-010 instr_valid  out  1  instr available to the consumer; high exactly while state is ISSUE.
REQ-011 instr_ready  in  1  consumer accepts instr this cycle.
REQ-012 branch_en  in  1  at acceptance, take branch_off instead of STEP.
REQ-013 branch_off  in  WORD_SIZE  signed branch offset, sampled only at acceptance.
REQ-014 halt  in  1  at acceptance, stop sequencing.
REQ-015 adj  out  WORD_SIZE  signed, registered; the instruction pointer adds it on every update_clk edge.
REQ-016 retired  out  WORD_SIZE  count of accepted instructions.
REQ-017 halted  out  1  high in HALTED state.
REQ-018 fault  out  1  sticky memory-timeout flag.

Function
REQ-019 States: FETCH, ISSUE, ADVANCE, HALTED.
REQ-020 FETCH: on mem_ack=1, instr <= mem_rdata and next state is ISSUE; otherwise remain in FETCH.
REQ-021 ISSUE: on instr_ready=1 (acceptance), retired <= retired+1 and instr_valid drops on the following cycle.
REQ-022 Acceptance with halt=0: adj <= (branch_en ? branch_off : STEP) and next state is ADVANCE.
REQ-023 Acceptance with halt=1: adj stays 0 and next state is HALTED; halt overrides branch_en.
REQ-024 ADVANCE lasts exactly one cycle: the instruction pointer consumes adj on that edge, adj <= 0, and next state is FETCH.
REQ-025 adj SHALL be nonzero for at most one cycle per accepted instruction and 0 in every other state.
REQ-026 Minimum throughput is 3 cycles per instruction (FETCH, ISSUE, ADVANCE) with mem_ack and instr_ready held high.
REQ-027 branch_off=0 SHALL produce adj=0 in ADVANCE: a legal refetch of the same address.
REQ-028 Offset arithmetic is two's complement at WORD_SIZE with no saturation.
REQ-029 retired wraps from 2^WORD_SIZE-1 to 0.
REQ-030 Timeout counter: cleared on entry to FETCH; incremented for each FETCH cycle with mem_ack=0.
REQ-031 Timeout fault: if mem_ack is still 0 on the TIMEOUT-th consecutive FETCH cycle, fault <= 1 and next state is HALTED.
REQ-032 An ack arriving on the TIMEOUT-th cycle takes priority over the timeout.
REQ-033 HALTED is terminal until reset: all inputs are ignored, mem_req=0, instr_valid=0, adj=0.
REQ-034 instr holds its value outside FETCH-with-ack.

Reset
REQ-035 On reset_clk high, immediately (asynchronously): state=FETCH, adj=0, instr=0, retired=0, fault=0, halted=0, timeout counter=0.
REQ-036 Reset asserted mid-instruction (ISSUE or ADVANCE) SHALL discard that instruction: no increment of retired and adj forced to 0.
REQ-037 After reset deasserts, mem_req is high in the first cycle.

Verification
REQ-038 Sequential: mem_ack=1, mem_rdata=0x1234, instr_ready=1 continuously -> instr=0x1234; adj=1 exactly every third cycle; retired=3 after 9 cycles.
REQ-039 Branch: accept with branch_en=1, branch_off=0xFFFC -> adj=0xFFFC for one cycle, then 0; an external IP at 0x0010 becomes 0x000C.
REQ-040 Backpressure: instr_ready=0 for 5 cycles in ISSUE -> instr_valid held and instr stable; adj=0 throughout; retired unchanged until acceptance.
REQ-041 Halt with branch: accept with halt=1, branch_en=1, branch_off=5 -> adj never 5; halted=1; mem_req stays 0 for 20 more cycles.
REQ-042 Timeout: mem_ack=0 for 8 FETCH cycles -> fault=1, halted=1; repeat with ack on the 8th cycle -> fault=0, state ISSUE.
REQ-043 Reset mid-ADVANCE with adj=3 -> adj=0 without waiting for a clock edge; retired=0; mem_req=1 on the next cycle.

Source files
------------

// File: rtl/ip_sequencer_if.sv
// Fetch/issue bus between the instruction sequencer and its memory, consumer and IP datapath.
interface ip_sequencer_if #(
  parameter int WORD_SIZE = 16
);
  logic                 mem_req;
  logic                 mem_ack;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic [WORD_SIZE-1:0] instr;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 branch_en;
  logic [WORD_SIZE-1:0] branch_off;
  logic                 halt;
  logic [WORD_SIZE-1:0] adj;
  logic [WORD_SIZE-1:0] retired;
  logic                 halted;
  logic                 fault;

  modport master (
    output mem_req, instr, instr_valid, adj, retired, halted, fault,
    input  mem_ack, mem_rdata, instr_ready, branch_en, branch_off, halt
  );

  modport slave (
    input  mem_req, instr, instr_valid, adj, retired, halted, fault,
    output mem_ack, mem_rdata, instr_ready, branch_en, branch_off, halt
  );
endinterface

// File: rtl/ip_sequencer.sv
// Fetch -> issue -> advance sequencer; emits a one-cycle signed IP adjustment per accepted
// instruction and halts on request or on a memory fetch timeout.
module ip_sequencer #(
  parameter int WORD_SIZE = 16,
  parameter int STEP      = 1,
  parameter int TIMEOUT   = 8
) (
  input  logic           update_clk,
  input  logic           reset_clk,
  ip_sequencer_if.master bus
);
  typedef enum logic [1:0] {FETCH, ISSUE, ADVANCE, HALTED} state_t;

  localparam logic [WORD_SIZE-1:0] STEP_W = WORD_SIZE'(STEP);
  localparam logic [WORD_SIZE-1:0] T_LAST = WORD_SIZE'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic [WORD_SIZE-1:0] instr_q, adj_q, retired_q, tcnt_q;
  logic                 fault_q;
  logic                 fetch_ack, fetch_tmo, accept;

  assign fetch_ack = (state == FETCH) && bus.mem_ack;
  // tcnt_q holds the number of prior ack-less cycles, so the TIMEOUT-th cycle sees TIMEOUT-1
  assign fetch_tmo = (state == FETCH) && !bus.mem_ack && (tcnt_q == T_LAST);
  assign accept    = (state == ISSUE) && bus.instr_ready;

  always_ff @(posedge update_clk or posedge reset_clk) begin
    if (reset_clk) state <= FETCH;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (fetch_ack)      state_nxt = ISSUE;
        else if (fetch_tmo) state_nxt = HALTED;
      end
      ISSUE: begin
        if (accept) state_nxt = bus.halt ? HALTED : ADVANCE;
      end
      ADVANCE: state_nxt = FETCH;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge update_clk or posedge reset_clk) begin
    if (reset_clk) begin
      instr_q   <= '0;
      adj_q     <= '0;
      retired_q <= '0;
      tcnt_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      if (fetch_ack) instr_q <= bus.mem_rdata;
      if (accept)    retired_q <= retired_q + WORD_SIZE'(1);
      // adj is live only during ADVANCE; halt wins over branch and leaves it at zero
      if (accept && !bus.halt) adj_q <= bus.branch_en ? bus.branch_off : STEP_W;
      else                     adj_q <= '0;
      if (state != FETCH)    tcnt_q <= '0;
      else if (!bus.mem_ack) tcnt_q <= tcnt_q + WORD_SIZE'(1);
      if (fetch_tmo) fault_q <= 1'b1;
    end
  end

  assign bus.mem_req     = (state == FETCH);
  assign bus.instr_valid = (state == ISSUE);
  assign bus.halted      = (state == HALTED);
  assign bus.instr       = instr_q;
  assign bus.adj         = adj_q;
  assign bus.retired     = retired_q;
  assign bus.fault       = fault_q;

  a_adj_only_advance: assert property (@(posedge update_clk) disable iff (reset_clk)
    (state != ADVANCE) |-> (adj_q == '0));
  a_halted_terminal: assert property (@(posedge update_clk) disable iff (reset_clk)
    (state == HALTED) |=> (state == HALTED));
endmodule

// File: tb/tb_ip_sequencer.sv
// Directed bench for ip_sequencer: one task per scenario, checks on the falling edge.
module tb_ip_sequencer;
  localparam int W = 16;

  logic update_clk = 1'b0;
  logic reset_clk  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ip_sequencer_if #(.WORD_SIZE(W)) bus ();

  ip_sequencer #(.WORD_SIZE(W), .STEP(1), .TIMEOUT(8)) dut (
    .update_clk (update_clk),
    .reset_clk  (reset_clk),
    .bus        (bus.master)
  );

  always #5 update_clk = ~update_clk;

  // external instruction pointer consuming adj on every edge
  logic [W-1:0] ip = '0;
  logic [W-1:0] ip_init = '0;
  logic         ip_load = 1'b0;
  always @(posedge update_clk) begin
    if (ip_load) ip <= ip_init;
    else         ip <= ip + bus.adj;
  end

  task automatic do_reset();
    reset_clk      = 1'b1;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    bus.instr_ready = 1'b0;
    bus.branch_en  = 1'b0;
    bus.branch_off = '0;
    bus.halt       = 1'b0;
    ip_load        = 1'b0;
    @(negedge update_clk);
    @(negedge update_clk);
    reset_clk = 1'b0;
  endtask

  task automatic test_reset();
    reset_clk = 1'b1;
    @(negedge update_clk);
    checks++;
    if ({bus.mem_req, bus.instr_valid, bus.halted, bus.fault} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 1000",
               {bus.mem_req, bus.instr_valid, bus.halted, bus.fault});
    end
    checks++;
    if ({bus.adj, bus.instr, bus.retired} !== {3{16'h0000}}) begin
      errors++;
      $display("FAIL reset_regs: adj=%h instr=%h retired=%h want 0", bus.adj, bus.instr, bus.retired);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234; bus.instr_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge update_clk);
      checks++;
      if (bus.adj !== ((k % 3 == 2) ? 16'd1 : 16'd0)) begin
        errors++;
        $display("FAIL seq_adj cycle %0d: got %h want %h", k, bus.adj, (k % 3 == 2) ? 16'd1 : 16'd0);
      end
      checks++;
      if ({bus.mem_req, bus.instr_valid} !== {k % 3 == 0, k % 3 == 1}) begin
        errors++;
        $display("FAIL seq_hs cycle %0d: req/valid got %b%b want %b%b", k,
                 bus.mem_req, bus.instr_valid, k % 3 == 0, k % 3 == 1);
      end
    end
    checks++;
    if (bus.instr !== 16'h1234) begin
      errors++;
      $display("FAIL seq_instr: got %h want 1234", bus.instr);
    end
    checks++;
    if (bus.retired !== 16'd3) begin
      errors++;
      $display("FAIL seq_retired: got %0d want 3", bus.retired);
    end
  endtask

  task automatic test_branch();
    do_reset();
    ip_init = 16'h0010; ip_load = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hABCD;
    @(negedge update_clk);
    ip_load = 1'b0;
    checks++;
    if ({bus.instr_valid, bus.instr} !== {1'b1, 16'hABCD}) begin
      errors++;
      $display("FAIL br_issue: valid=%b instr=%h want 1 abcd", bus.instr_valid, bus.instr);
    end
    bus.mem_ack = 1'b0; bus.instr_ready = 1'b1; bus.branch_en = 1'b1; bus.branch_off = 16'hFFFC;
    @(negedge update_clk);
    checks++;
    if (bus.adj !== 16'hFFFC) begin
      errors++;
      $display("FAIL br_adj: got %h want fffc", bus.adj);
    end
    bus.instr_ready = 1'b0; bus.branch_en = 1'b0;
    @(negedge update_clk);
    checks++;
    if ({bus.adj, bus.mem_req} !== {16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL br_after: adj=%h req=%b want 0000 1", bus.adj, bus.mem_req);
    end
    checks++;
    if (ip !== 16'h000C) begin
      errors++;
      $display("FAIL br_ip: got %h want 000c", ip);
    end
  endtask

  task automatic test_branch_zero();
    do_reset();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0042;
    @(negedge update_clk);
    bus.instr_ready = 1'b1; bus.branch_en = 1'b1; bus.branch_off = 16'h0000;
    @(negedge update_clk);
    checks++;
    if ({bus.adj, bus.mem_req, bus.instr_valid, bus.retired} !== {16'h0000, 2'b00, 16'd1}) begin
      errors++;
      $display("FAIL br0_advance: adj=%h req=%b valid=%b retired=%0d want 0000 0 0 1",
               bus.adj, bus.mem_req, bus.instr_valid, bus.retired);
    end
    bus.instr_ready = 1'b0; bus.mem_ack = 1'b0;
    @(negedge update_clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL br0_refetch: mem_req got %b want 1", bus.mem_req);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h5A5A;
    @(negedge update_clk);
    bus.mem_rdata = 16'h1111;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if ({bus.instr_valid, bus.instr, bus.adj, bus.retired} !== {1'b1, 16'h5A5A, 16'h0, 16'h0}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b instr=%h adj=%h retired=%0d", k,
                 bus.instr_valid, bus.instr, bus.adj, bus.retired);
      end
      if (k == 5) bus.instr_ready = 1'b1;
      @(negedge update_clk);
    end
    checks++;
    if ({bus.instr_valid, bus.adj, bus.retired} !== {1'b0, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL bp_accept: valid=%b adj=%h retired=%0d want 0 0001 1",
               bus.instr_valid, bus.adj, bus.retired);
    end
  endtask

  task automatic test_halt_branch();
    do_reset();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0007;
    @(negedge update_clk);
    bus.instr_ready = 1'b1; bus.halt = 1'b1; bus.branch_en = 1'b1; bus.branch_off = 16'd5;
    @(negedge update_clk);
    checks++;
    if ({bus.halted, bus.adj, bus.retired} !== {1'b1, 16'h0, 16'd1}) begin
      errors++;
      $display("FAIL halt_enter: halted=%b adj=%h retired=%0d want 1 0000 1",
               bus.halted, bus.adj, bus.retired);
    end
    bus.halt = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge update_clk);
      checks++;
      if ({bus.mem_req, bus.instr_valid, bus.halted, bus.adj} !== {3'b001, 16'h0}) begin
        errors++;
        $display("FAIL halt_hold cycle %0d: req=%b valid=%b halted=%b adj=%h", k,
                 bus.mem_req, bus.instr_valid, bus.halted, bus.adj);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      @(negedge update_clk);
      checks++;
      if ({bus.mem_req, bus.fault, bus.halted} !== 3'b100) begin
        errors++;
        $display("FAIL tmo_wait cycle %0d: req/fault/halted got %b want 100", k,
                 {bus.mem_req, bus.fault, bus.halted});
      end
    end
    @(negedge update_clk);
    checks++;
    if ({bus.mem_req, bus.fault, bus.halted} !== 3'b011) begin
      errors++;
      $display("FAIL tmo_fault: req/fault/halted got %b want 011", {bus.mem_req, bus.fault, bus.halted});
    end
    do_reset();
    for (int k = 1; k <= 7; k++) @(negedge update_clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
    @(negedge update_clk);
    checks++;
    if ({bus.fault, bus.halted, bus.instr_valid, bus.instr} !== {3'b001, 16'hBEEF}) begin
      errors++;
      $display("FAIL tmo_late_ack: fault=%b halted=%b valid=%b instr=%h want 0 0 1 beef",
               bus.fault, bus.halted, bus.instr_valid, bus.instr);
    end
  endtask

  task automatic test_reset_mid_advance();
    do_reset();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'h0099;
    @(negedge update_clk);
    bus.mem_ack = 1'b0; bus.instr_ready = 1'b1; bus.branch_en = 1'b1; bus.branch_off = 16'd3;
    @(negedge update_clk);
    checks++;
    if (bus.adj !== 16'd3) begin
      errors++;
      $display("FAIL rst_pre_adj: got %h want 0003", bus.adj);
    end
    #1 reset_clk = 1'b1;
    #1;
    checks++;
    if ({bus.adj, bus.retired, bus.mem_req} !== {16'h0, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL rst_async: adj=%h retired=%0d req=%b want 0000 0 1", bus.adj, bus.retired, bus.mem_req);
    end
    #1 reset_clk = 1'b0;
    bus.instr_ready = 1'b0; bus.branch_en = 1'b0;
    @(negedge update_clk);
    checks++;
    if ({bus.adj, bus.retired, bus.mem_req} !== {16'h0, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL rst_after: adj=%h retired=%0d req=%b want 0000 0 1", bus.adj, bus.retired, bus.mem_req);
    end
  endtask

  initial begin
    bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.instr_ready = 1'b0;
    bus.branch_en = 1'b0; bus.branch_off = '0; bus.halt = 1'b0;
    test_reset();
    test_sequential();
    test_branch();
    test_branch_zero();
    test_backpressure();
    test_halt_branch();
    test_timeout();
    test_reset_mid_advance();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
